// File: rtl/afifo_wr_capture_if.sv
// Purpose: bundles the monitored FIFO write port and the capture-buffer read side.
// Latency: none, signal container only.
// Backpressure: cap_ready from the consumer holds the capture head in place.
interface afifo_wr_capture_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CAP_DEPTH  = 8,
  parameter int SEQ_WIDTH  = 16
);
  localparam int LW = $clog2(CAP_DEPTH) + 1;

  // monitored write port and consumer handshake
  logic                  en;
  logic                  winc;
  logic                  wfull;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  cap_ready;

  // capture head, occupancy and statistics
  logic                  cap_valid;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_rej;
  logic [SEQ_WIDTH-1:0]  cap_seq;
  logic [LW-1:0]         cap_level;
  logic [SEQ_WIDTH-1:0]  acc_cnt;
  logic [SEQ_WIDTH-1:0]  rej_cnt;
  logic [SEQ_WIDTH-1:0]  lost_cnt;
  logic                  lost_flag;

  modport master (
    output en, winc, wfull, wdata, cap_ready,
    input  cap_valid, cap_data, cap_rej, cap_seq, cap_level,
    input  acc_cnt, rej_cnt, lost_cnt, lost_flag
  );

  modport slave (
    input  en, winc, wfull, wdata, cap_ready,
    output cap_valid, cap_data, cap_rej, cap_seq, cap_level,
    output acc_cnt, rej_cnt, lost_cnt, lost_flag
  );
endinterface

// File: rtl/afifo_wr_capture.sv
// Purpose: snoops a FIFO write port, logs write events with sequence numbers into a FWFT buffer, keeps statistics.
// Latency: an event sampled at one edge is on cap_* after that edge when the buffer was empty.
// Backpressure: cap_ready low holds the head; events arriving with the buffer full and no pop are dropped and counted.
module afifo_wr_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int CAP_DEPTH  = 8,
  parameter int SEQ_WIDTH  = 16,
  parameter int MODE       = 0
) (
  input  logic              wclk,
  input  logic              wrst,
  afifo_wr_capture_if.slave bus
);
  localparam int AW = $clog2(CAP_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [SEQ_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [LW-1:0] LVL_FULL = LW'(CAP_DEPTH);
  localparam bit LOG_REJECTS = (MODE == 1);

  typedef struct packed {
    logic                  rej;
    logic [SEQ_WIDTH-1:0]  seq;
    logic [DATA_WIDTH-1:0] dat;
  } entry_t;

  entry_t               mem [CAP_DEPTH];
  entry_t               head;
  entry_t               new_entry;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic [SEQ_WIDTH-1:0] seq_cnt;
  logic [SEQ_WIDTH-1:0] acc_cnt;
  logic [SEQ_WIDTH-1:0] rej_cnt;
  logic [SEQ_WIDTH-1:0] lost_cnt;
  logic                 lost_flag;

  logic acc_evt;
  logic rej_evt;
  logic evt;
  logic pop;
  logic push;
  logic drop;

  // Classify the current write attempt and decide whether it fits in the buffer.
  always_comb begin
    acc_evt       = 1'b0;
    rej_evt       = 1'b0;
    evt           = 1'b0;
    pop           = 1'b0;
    push          = 1'b0;
    drop          = 1'b0;
    new_entry     = '0;
    if (!wrst) begin
      acc_evt = bus.en && bus.winc && !bus.wfull;
      rej_evt = bus.en && bus.winc && bus.wfull;
      evt     = acc_evt || (LOG_REJECTS && rej_evt);
      pop     = (level != '0) && bus.cap_ready;
      // a pop at the same edge frees the slot, so a full buffer still accepts
      push    = evt && ((level != LVL_FULL) || pop);
      drop    = evt && !push;
    end
    new_entry.dat = bus.wdata;
    new_entry.seq = seq_cnt;
    new_entry.rej = LOG_REJECTS && bus.wfull;
  end

  // Buffer storage: new events land at the tail; contents are qualified by level, so no reset.
  always_ff @(posedge wclk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  // Pointers and occupancy; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sequence numbering wraps; statistics counters saturate.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      seq_cnt   <= '0;
      acc_cnt   <= '0;
      rej_cnt   <= '0;
      lost_cnt  <= '0;
      lost_flag <= 1'b0;
    end else begin
      if (evt) seq_cnt <= seq_cnt + 1'b1;
      if (acc_evt && (acc_cnt != CNT_MAX)) acc_cnt <= acc_cnt + 1'b1;
      if (rej_evt && (rej_cnt != CNT_MAX)) rej_cnt <= rej_cnt + 1'b1;
      if (drop) begin
        lost_flag <= 1'b1;
        if (lost_cnt != CNT_MAX) lost_cnt <= lost_cnt + 1'b1;
      end
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.cap_valid = (level != '0);
  assign bus.cap_data  = head.dat;
  assign bus.cap_rej   = head.rej;
  assign bus.cap_seq   = head.seq;
  assign bus.cap_level = level;
  assign bus.acc_cnt   = acc_cnt;
  assign bus.rej_cnt   = rej_cnt;
  assign bus.lost_cnt  = lost_cnt;
  assign bus.lost_flag = lost_flag;
endmodule

// File: tb/tb_afifo_wr_capture.sv
// Purpose: exercises three capture instances (MODE 0, MODE 1, narrow SEQ_WIDTH) with shared stimulus.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: cap_ready is driven directly by the tests.
module tb_afifo_wr_capture;
  localparam int DEPTH = 8;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  afifo_wr_capture_if #(.DATA_WIDTH(8), .CAP_DEPTH(DEPTH), .SEQ_WIDTH(16)) b0 ();
  afifo_wr_capture_if #(.DATA_WIDTH(8), .CAP_DEPTH(DEPTH), .SEQ_WIDTH(16)) b1 ();
  afifo_wr_capture_if #(.DATA_WIDTH(8), .CAP_DEPTH(DEPTH), .SEQ_WIDTH(4))  b2 ();

  afifo_wr_capture #(.DATA_WIDTH(8), .CAP_DEPTH(DEPTH), .SEQ_WIDTH(16), .MODE(0))
    dut0 (.wclk(wclk), .wrst(wrst), .bus(b0));
  afifo_wr_capture #(.DATA_WIDTH(8), .CAP_DEPTH(DEPTH), .SEQ_WIDTH(16), .MODE(1))
    dut1 (.wclk(wclk), .wrst(wrst), .bus(b1));
  afifo_wr_capture #(.DATA_WIDTH(8), .CAP_DEPTH(DEPTH), .SEQ_WIDTH(4), .MODE(0))
    dut2 (.wclk(wclk), .wrst(wrst), .bus(b2));

  int errors = 0;
  int checks = 0;

  // reference model: a queue of logged events plus plain integer statistics
  typedef struct {
    logic [7:0] d;
    logic       r;
    int         s;
  } ent_t;

  typedef struct {
    logic        vld;
    logic [7:0]  d;
    logic        r;
    logic [31:0] seq;
    logic [31:0] lvl;
    logic [31:0] acc;
    logic [31:0] rej;
    logic [31:0] lost;
    logic        lf;
  } obs_t;

  ent_t q0[$];
  ent_t q1[$];
  ent_t q2[$];
  int m_acc[3];
  int m_rej[3];
  int m_lost[3];
  int m_seq[3];
  bit m_lf[3];
  int m_mode[3] = '{0, 1, 0};
  int m_smax[3] = '{65535, 65535, 15};

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ent_t qhead(int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(int k, ent_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic model_step(int k, bit r, bit e, bit w, bit f, logic [7:0] d, bit rdy);
    ent_t ne;
    bit   pop;
    bit   evt;
    if (r) begin
      case (k)
        0:       q0.delete();
        1:       q1.delete();
        default: q2.delete();
      endcase
      m_acc[k] = 0; m_rej[k] = 0; m_lost[k] = 0; m_seq[k] = 0; m_lf[k] = 0;
      return;
    end
    pop = (qsize(k) > 0) && rdy;
    evt = e && w && (m_mode[k] == 1 || !f);
    if (e && w && !f && m_acc[k] < m_smax[k]) m_acc[k]++;
    if (e && w && f && m_rej[k] < m_smax[k]) m_rej[k]++;
    if (pop) qpop(k);
    if (evt) begin
      if (qsize(k) < DEPTH) begin
        ne.d = d; ne.r = f; ne.s = m_seq[k];
        qpush(k, ne);
      end else begin
        if (m_lost[k] < m_smax[k]) m_lost[k]++;
        m_lf[k] = 1'b1;
      end
      m_seq[k] = (m_seq[k] + 1) % (m_smax[k] + 1);
    end
  endtask

  function automatic obs_t obs(int k);
    obs_t o;
    case (k)
      0: begin
        o.vld = b0.cap_valid; o.d = b0.cap_data; o.r = b0.cap_rej; o.seq = 32'(b0.cap_seq);
        o.lvl = 32'(b0.cap_level); o.acc = 32'(b0.acc_cnt); o.rej = 32'(b0.rej_cnt);
        o.lost = 32'(b0.lost_cnt); o.lf = b0.lost_flag;
      end
      1: begin
        o.vld = b1.cap_valid; o.d = b1.cap_data; o.r = b1.cap_rej; o.seq = 32'(b1.cap_seq);
        o.lvl = 32'(b1.cap_level); o.acc = 32'(b1.acc_cnt); o.rej = 32'(b1.rej_cnt);
        o.lost = 32'(b1.lost_cnt); o.lf = b1.lost_flag;
      end
      default: begin
        o.vld = b2.cap_valid; o.d = b2.cap_data; o.r = b2.cap_rej; o.seq = 32'(b2.cap_seq);
        o.lvl = 32'(b2.cap_level); o.acc = 32'(b2.acc_cnt); o.rej = 32'(b2.rej_cnt);
        o.lost = 32'(b2.lost_cnt); o.lf = b2.lost_flag;
      end
    endcase
    return o;
  endfunction

  // drive all three instances, advance one edge, update the model
  task automatic cycle(bit r, bit e, bit w, bit f, logic [7:0] d, bit rdy);
    wrst = r;
    b0.en = e; b0.winc = w; b0.wfull = f; b0.wdata = d; b0.cap_ready = rdy;
    b1.en = e; b1.winc = w; b1.wfull = f; b1.wdata = d; b1.cap_ready = rdy;
    b2.en = e; b2.winc = w; b2.wfull = f; b2.wdata = d; b2.cap_ready = rdy;
    @(posedge wclk);
    for (int k = 0; k < 3; k++) model_step(k, r, e, w, f, d, rdy);
    #1;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_reset();
    obs_t o;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      checks++; if (o.vld !== 1'b0) begin errors++; $display("FAIL reset_valid k=%0d got=%0b exp=0", k, o.vld); end
      checks++; if (o.lvl !== 0) begin errors++; $display("FAIL reset_level k=%0d got=%0d exp=0", k, o.lvl); end
      checks++; if (o.acc !== 0 || o.rej !== 0 || o.lost !== 0) begin
        errors++; $display("FAIL reset_counters k=%0d got=%0d/%0d/%0d exp=0/0/0", k, o.acc, o.rej, o.lost);
      end
      checks++; if (o.lf !== 1'b0) begin errors++; $display("FAIL reset_lost_flag k=%0d got=%0b exp=0", k, o.lf); end
    end
  endtask

  task automatic test_basic();
    obs_t o;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 0, 8'hA1 + 8'(i), 1);
      o = obs(0);
      checks++; if (o.vld !== 1'b1 || o.d !== 8'hA1 + 8'(i) || o.seq !== i) begin
        errors++; $display("FAIL basic_head i=%0d got=v%0b d=%0h s=%0d exp=v1 d=%0h s=%0d", i, o.vld, o.d, o.seq, 8'hA1 + 8'(i), i);
      end
    end
    cycle(0, 0, 0, 0, 8'h00, 1);
    o = obs(0);
    checks++; if (o.lvl !== 0) begin errors++; $display("FAIL basic_level got=%0d exp=0", o.lvl); end
    checks++; if (o.acc !== 3) begin errors++; $display("FAIL basic_acc got=%0d exp=3", o.acc); end
  endtask

  task automatic test_reject();
    obs_t o;
    do_reset();
    cycle(0, 1, 1, 1, 8'h55, 0);
    o = obs(1);
    checks++; if (o.vld !== 1'b1 || o.d !== 8'h55 || o.r !== 1'b1) begin
      errors++; $display("FAIL rej_m1_entry got=v%0b d=%0h r=%0b exp=v1 d=55 r=1", o.vld, o.d, o.r);
    end
    checks++; if (o.rej !== 1 || o.acc !== 0) begin
      errors++; $display("FAIL rej_m1_counts got=rej%0d acc%0d exp=rej1 acc0", o.rej, o.acc);
    end
    o = obs(0);
    checks++; if (o.vld !== 1'b0 || o.rej !== 1) begin
      errors++; $display("FAIL rej_m0 got=v%0b rej%0d exp=v0 rej1", o.vld, o.rej);
    end
  endtask

  task automatic test_overflow();
    obs_t o;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0, 8'(i), 0);
    o = obs(0);
    checks++; if (o.lvl !== 8 || o.lost !== 2 || o.lf !== 1'b1) begin
      errors++; $display("FAIL ovf_state got=lvl%0d lost%0d lf%0b exp=lvl8 lost2 lf1", o.lvl, o.lost, o.lf);
    end
    for (int i = 0; i < 8; i++) begin
      o = obs(0);
      checks++; if (o.vld !== 1'b1 || o.seq !== i) begin
        errors++; $display("FAIL ovf_drain i=%0d got=v%0b s=%0d exp=v1 s=%0d", i, o.vld, o.seq, i);
      end
      cycle(0, 0, 0, 0, 8'h00, 1);
    end
    cycle(0, 1, 1, 0, 8'h77, 0);
    o = obs(0);
    checks++; if (o.vld !== 1'b1 || o.seq !== 10) begin
      errors++; $display("FAIL ovf_next_seq got=v%0b s=%0d exp=v1 s=10", o.vld, o.seq);
    end
  endtask

  task automatic test_full_pop();
    obs_t o;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 8'h10 + 8'(i), 0);
    cycle(0, 1, 1, 0, 8'hEE, 1);
    o = obs(0);
    checks++; if (o.lvl !== 8 || o.lost !== 0) begin
      errors++; $display("FAIL fullpop_state got=lvl%0d lost%0d exp=lvl8 lost0", o.lvl, o.lost);
    end
    for (int i = 1; i < 9; i++) begin
      o = obs(0);
      checks++; if (o.seq !== i || o.d !== ((i == 8) ? 8'hEE : 8'h10 + 8'(i))) begin
        errors++; $display("FAIL fullpop_order i=%0d got=d%0h s=%0d exp=d%0h s=%0d", i, o.d, o.seq,
                           (i == 8) ? 8'hEE : 8'h10 + 8'(i), i);
      end
      cycle(0, 0, 0, 0, 8'h00, 1);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0, 8'h30 + 8'(i), 0);
    cycle(1, 1, 1, 0, 8'h99, 1);
    o = obs(0);
    checks++; if (o.vld !== 1'b0 || o.acc !== 0 || o.lost !== 0 || o.lf !== 1'b0) begin
      errors++; $display("FAIL midrst_state got=v%0b acc%0d lost%0d lf%0b exp=v0 acc0 lost0 lf0", o.vld, o.acc, o.lost, o.lf);
    end
    cycle(0, 1, 1, 0, 8'h42, 0);
    o = obs(0);
    checks++; if (o.vld !== 1'b1 || o.seq !== 0 || o.d !== 8'h42) begin
      errors++; $display("FAIL midrst_first got=v%0b s=%0d d=%0h exp=v1 s=0 d=42", o.vld, o.seq, o.d);
    end
  endtask

  task automatic test_saturate();
    obs_t o;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1, 0, 8'(i), 1);
      o = obs(2);
      checks++; if (o.vld !== 1'b1 || o.seq !== (i % 16)) begin
        errors++; $display("FAIL sat_seq i=%0d got=v%0b s=%0d exp=v1 s=%0d", i, o.vld, o.seq, i % 16);
      end
    end
    o = obs(2);
    checks++; if (o.acc !== 15) begin errors++; $display("FAIL sat_acc got=%0d exp=15", o.acc); end
    o = obs(0);
    checks++; if (o.acc !== 20) begin errors++; $display("FAIL sat_acc_wide got=%0d exp=20", o.acc); end
  endtask

  task automatic test_random();
    obs_t o;
    ent_t h;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 2) == 0));
      for (int k = 0; k < 3; k++) begin
        o = obs(k);
        checks++; if (o.lvl !== qsize(k) || o.vld !== (qsize(k) > 0)) begin
          errors++; $display("FAIL rnd_level n=%0d k=%0d got=lvl%0d v%0b exp=lvl%0d", n, k, o.lvl, o.vld, qsize(k));
        end
        checks++; if (o.acc !== m_acc[k] || o.rej !== m_rej[k] || o.lost !== m_lost[k] || o.lf !== m_lf[k]) begin
          errors++; $display("FAIL rnd_counters n=%0d k=%0d got=%0d/%0d/%0d/%0b exp=%0d/%0d/%0d/%0b",
                             n, k, o.acc, o.rej, o.lost, o.lf, m_acc[k], m_rej[k], m_lost[k], m_lf[k]);
        end
        if (qsize(k) > 0) begin
          h = qhead(k);
          checks++; if (o.d !== h.d || o.r !== h.r || o.seq !== h.s) begin
            errors++; $display("FAIL rnd_head n=%0d k=%0d got=d%0h r%0b s%0d exp=d%0h r%0b s%0d",
                               n, k, o.d, o.r, o.seq, h.d, h.r, h.s);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
